usb_uart_tx_arbiter: RTL and testbench

// Shares the single host-bound byte stream of the USB UART (uart_in_data/valid/ready) between
// NUM_REQ independent byte sources (console, debug dump, status reporter, ...). Grants one source
// at a time in round-robin order and holds the grant for a burst so that bursts are not interleaved.

---
 rtl/usb_uart_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_usb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : usb_uart_tx_arbiter
// Description : Round-robin arbiter that shares the host-bound byte stream of
//               the USB UART between NUM_REQ byte sources. A grant is held for
//               a burst and released after MAX_BURST bytes or after GAP idle
//               cycles of the owner. Data is passed through combinationally.
// Ports       : clk_48mhz      - system clock
//               reset          - asynchronous active-high reset
//               req_data       - byte of requester i at [8*i+7:8*i]
//               req_valid      - requester i has a byte
//               req_ready      - requester i byte accepted (valid & ready)
//               uart_in_data   - byte to usb_uart_np
//               uart_in_valid  - byte valid to usb_uart_np
//               uart_in_ready  - usb_uart_np accepts byte
//               grant          - one-hot current owner, zero when idle
//               busy           - a grant is active
// Revision    : 1.0 - initial release
// ============================================================================
module usb_uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64,
    parameter int GAP       = 16
) (
    input  logic                 clk_48mhz,
    input  logic                 reset,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_in_data,
    output logic                 uart_in_valid,
    input  logic                 uart_in_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int c_idx_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_bcnt_w = $clog2(MAX_BURST + 1);
    localparam int c_gcnt_w = $clog2(GAP + 1);

    // Counter values one step before the release threshold: the release is
    // decided on the edge that would take the counter to the threshold.
    localparam logic [c_bcnt_w-1:0] c_burst_last = c_bcnt_w'(MAX_BURST - 1);
    localparam logic [c_gcnt_w-1:0] c_gap_last   = c_gcnt_w'(GAP - 1);
    localparam logic [c_idx_w-1:0]  c_last_init  = c_idx_w'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    w_grant_nxt;
    logic [c_idx_w-1:0]    r_owner;
    logic [c_idx_w-1:0]    w_owner_nxt;
    logic [c_idx_w-1:0]    r_last;
    logic [c_idx_w-1:0]    w_last_nxt;
    logic [c_bcnt_w-1:0]   r_byte_cnt;
    logic [c_bcnt_w-1:0]   w_byte_cnt_nxt;
    logic [c_gcnt_w-1:0]   r_gap_cnt;
    logic [c_gcnt_w-1:0]   w_gap_cnt_nxt;

    logic                  w_found;
    logic [c_idx_w-1:0]    w_sel;
    logic [c_idx_w-1:0]    w_cand;
    logic                  w_owner_valid;
    logic [7:0]            w_owner_data;
    logic                  w_xfer;
    logic                  w_burst_done;
    logic                  w_gap_done;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester after the previous owner.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_cand  = r_last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_idx_w'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Owner's valid/data selected through the one-hot grant, so the mux is
    // naturally zero when no grant is held.
    always_comb begin
        w_owner_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_owner_data = req_data[8*i +: 8];
            end
        end
    end

    assign w_owner_valid = |(req_valid & r_grant);
    assign w_xfer        = (r_state == ST_GRANT) && w_owner_valid && uart_in_ready;
    assign w_burst_done  = w_xfer && (r_byte_cnt == c_burst_last);
    assign w_gap_done    = (r_state == ST_GRANT) && !w_owner_valid && (r_gap_cnt == c_gap_last);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_byte_cnt_nxt = r_byte_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        req_ready      = '0;
        uart_in_data   = 8'h00;
        uart_in_valid  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ST_GRANT;
                    w_grant_nxt    = NUM_REQ'(1) << w_sel;
                    w_owner_nxt    = w_sel;
                    w_byte_cnt_nxt = '0;
                    w_gap_cnt_nxt  = '0;
                end
            end

            ST_GRANT: begin
                uart_in_data  = w_owner_data;
                uart_in_valid = w_owner_valid;
                req_ready     = r_grant & {NUM_REQ{uart_in_ready}};

                if (w_xfer) begin
                    w_byte_cnt_nxt = r_byte_cnt + c_bcnt_w'(1);
                end
                if (w_owner_valid) begin
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + c_gcnt_w'(1);
                end

                // Either limit ends the burst; both at once is one release.
                if (w_burst_done || w_gap_done) begin
                    w_state_nxt    = ST_IDLE;
                    w_grant_nxt    = '0;
                    w_last_nxt     = r_owner;
                    w_byte_cnt_nxt = '0;
                    w_gap_cnt_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_last     <= c_last_init;
            r_byte_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_usb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_uart_tx_arbiter
// Description : Self-checking bench for usb_uart_tx_arbiter (NUM_REQ=4,
//               MAX_BURST=4, GAP=16). Vector table for the basic round-robin
//               burst pattern, directed sequences for gap release, ready
//               throttling, full contention and reset mid-burst, then random
//               traffic against a behavioural arbiter model and a byte
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_uart_tx_arbiter;

    localparam int N         = 4;
    localparam int MAX_BURST = 4;
    localparam int GAP       = 16;

    logic           clk_48mhz = 1'b0;
    logic           reset     = 1'b1;
    logic [N*8-1:0] req_data  = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_in_data;
    logic           uart_in_valid;
    logic           uart_in_ready = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;

    usb_uart_tx_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MAX_BURST),
        .GAP       (GAP)
    ) u_dut (
        .clk_48mhz     (clk_48mhz),
        .reset         (reset),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .uart_in_data  (uart_in_data),
        .uart_in_valid (uart_in_valid),
        .uart_in_ready (uart_in_ready),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model state ----------------
    int m_owner;   // -1 when nobody holds the stream
    int m_last;
    int m_bytes;
    int m_gaps;

    // Per-requester pending byte queues (circular) and "valid raised" flags
    logic [7:0] qmem [N][256];
    int         qh [N];
    int         qt [N];
    bit         hold [N];

    logic [7:0] exp_stream [$];
    logic [7:0] dut_stream [$];

    function automatic int qcnt(input int i);
        return qt[i] - qh[i];
    endfunction

    task automatic qpush(input int i, input logic [7:0] b);
        qmem[i][qt[i] % 256] = b;
        qt[i]++;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_bytes = 0;
        m_gaps  = 0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        req_valid     = '1;
        uart_in_ready = 1'b1;
        repeat (2) @(posedge clk_48mhz);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(uart_in_valid), 32'h0);
        check("rst_data", 32'(uart_in_data), 32'h0);
        req_valid     = '0;
        req_data      = '0;
        uart_in_ready = 1'b0;
        reset         = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            qh[i]   = 0;
            qt[i]   = 0;
            hold[i] = 1'b0;
        end
        exp_stream.delete();
        dut_stream.delete();
    endtask

    // One clock of traffic: drive, check against the model, advance model.
    // Entered and left 1 time unit after a rising edge.
    task automatic run_cycle(input int pv, input bit rdy);
        logic [N-1:0] eg;
        logic         ev;
        logic [7:0]   ed;
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && qcnt(i) > 0 && $urandom_range(99) < pv) hold[i] = 1'b1;
            req_valid[i]       = hold[i];
            req_data[8*i +: 8] = (qcnt(i) > 0) ? qmem[i][qh[i] % 256] : 8'h00;
        end
        uart_in_ready = rdy;

        @(negedge clk_48mhz);
        eg = '0; ev = 1'b0; ed = 8'h00;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ev = req_valid[m_owner];
            ed = req_data[8*m_owner +: 8];
        end
        check("m_grant", 32'(grant), 32'(eg));
        check("m_busy", 32'(busy), 32'(m_owner >= 0));
        check("m_valid", 32'(uart_in_valid), 32'(ev));
        check("m_data", 32'(uart_in_data), 32'(ed));
        check("m_ready", 32'(req_ready), 32'(rdy ? eg : '0));
        if (uart_in_valid && uart_in_ready) dut_stream.push_back(uart_in_data);

        @(posedge clk_48mhz);
        if (m_owner < 0) begin
            if (|req_valid) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
                end
                m_bytes = 0;
                m_gaps  = 0;
            end
        end else begin
            if (req_valid[m_owner] && rdy) begin
                exp_stream.push_back(qmem[m_owner][qh[m_owner] % 256]);
                qh[m_owner]++;
                hold[m_owner] = 1'b0;
                m_bytes++;
            end
            if (req_valid[m_owner]) m_gaps = 0;
            else m_gaps++;
            if (m_bytes == MAX_BURST || m_gaps == GAP) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        #1;
    endtask

    task automatic compare_streams(input string name);
        check({name, "_count"}, 32'(dut_stream.size()), 32'(exp_stream.size()));
        for (int i = 0; i < exp_stream.size() && i < dut_stream.size(); i++) begin
            check({name, "_byte"}, 32'(dut_stream[i]), 32'(exp_stream[i]));
        end
        exp_stream.delete();
        dut_stream.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] rv;
        logic         rdy;
        logic [N-1:0] g;
        logic         b;
        logic         v;
        logic [7:0]   d;
        logic [N-1:0] r;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int own [12] = '{-1, 0, 0, 0, 0, -1, 2, 2, 2, 2, -1, 0};
        logic [N*8-1:0] tdata;
        logic [N-1:0]   order [5];
        logic [N-1:0]   prev_g;
        int             nrec;
        int             guard;

        // Requester i presents byte 0x10*(i+1) throughout the table run
        tdata = {8'h40, 8'h30, 8'h20, 8'h10};
        for (int r = 0; r < 12; r++) begin
            tbl[r].rv  = 4'b0101;
            tbl[r].rdy = 1'b1;
            tbl[r].g   = (own[r] >= 0) ? N'(1) << own[r] : '0;
            tbl[r].b   = (own[r] >= 0);
            tbl[r].v   = (own[r] >= 0);
            tbl[r].d   = (own[r] >= 0) ? 8'(8'h10 * (own[r] + 1)) : 8'h00;
            tbl[r].r   = tbl[r].g;
        end

        // ---- 1: req0/req2 alternate in bursts of MAX_BURST ----
        do_reset();
        req_data = tdata;
        for (int r = 0; r < 12; r++) begin
            req_valid     = tbl[r].rv;
            uart_in_ready = tbl[r].rdy;
            @(negedge clk_48mhz);
            check($sformatf("t1_grant_r%0d", r), 32'(grant), 32'(tbl[r].g));
            check($sformatf("t1_busy_r%0d", r), 32'(busy), 32'(tbl[r].b));
            check($sformatf("t1_valid_r%0d", r), 32'(uart_in_valid), 32'(tbl[r].v));
            check($sformatf("t1_data_r%0d", r), 32'(uart_in_data), 32'(tbl[r].d));
            check($sformatf("t1_ready_r%0d", r), 32'(req_ready), 32'(tbl[r].r));
            @(posedge clk_48mhz);
            #1;
        end

        // ---- 2: req1 sends 3 bytes then goes quiet until GAP releases ----
        do_reset();
        qpush(1, 8'hA1); qpush(1, 8'hA2); qpush(1, 8'hA3);
        guard = 0;
        while (qcnt(1) > 0 && guard < 40) begin
            run_cycle(100, 1'b1);
            guard++;
        end
        check("t2_drained", 32'(qcnt(1)), 32'h0);
        check("t2_hold_0", 32'(grant), 32'h2);
        for (int c = 1; c <= GAP; c++) begin
            run_cycle(100, 1'b1);
            if (c < GAP) check($sformatf("t2_hold_%0d", c), 32'(grant), 32'h2);
        end
        check("t2_released_grant", 32'(grant), 32'h0);
        check("t2_released_busy", 32'(busy), 32'h0);
        compare_streams("t2_stream");

        // ---- 3: req0 with toggling uart_in_ready, bytes 0x00..0x09 ----
        do_reset();
        for (int i = 0; i < 10; i++) qpush(0, 8'(i));
        guard = 0;
        while (qcnt(0) > 0 && guard < 80) begin
            run_cycle(100, guard[0] == 1'b0);
            guard++;
        end
        check("t3_count", 32'(dut_stream.size()), 32'd10);
        for (int i = 0; i < 10 && i < dut_stream.size(); i++) begin
            check($sformatf("t3_byte%0d", i), 32'(dut_stream[i]), 32'(i));
        end
        compare_streams("t3_stream");

        // ---- 4: all four requesting, grant order 0,1,2,3,0 ----
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 8; j++) qpush(i, 8'(16 * i + j));
        end
        prev_g = '0;
        nrec   = 0;
        guard  = 0;
        while (nrec < 5 && guard < 80) begin
            run_cycle(100, 1'b1);
            if (grant != '0 && prev_g == '0) begin
                order[nrec] = grant;
                nrec++;
            end
            prev_g = grant;
            guard++;
        end
        check("t4_grants_seen", 32'(nrec), 32'd5);
        for (int i = 0; i < 5 && i < nrec; i++) begin
            check($sformatf("t4_order%0d", i), 32'(order[i]), 32'(N'(1) << (i % N)));
        end
        compare_streams("t4_stream");

        // ---- 5: reset mid-burst after 2 bytes, req0 wins again ----
        do_reset();
        for (int j = 0; j < 8; j++) qpush(0, 8'(8'hC0 + j));
        for (int j = 0; j < 4; j++) qpush(1, 8'(8'hD0 + j));
        guard = 0;
        while (!(m_owner == 0 && m_bytes == 2) && guard < 20) begin
            run_cycle(100, 1'b1);
            guard++;
        end
        check("t5_reached", 32'(m_bytes), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_grant", 32'(grant), 32'h0);
        check("t5_async_valid", 32'(uart_in_valid), 32'h0);
        check("t5_async_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(posedge clk_48mhz);
        #1;
        reset = 1'b0;
        run_cycle(100, 1'b1);
        check("t5_first_grant", 32'(grant), 32'h1);
        guard = 0;
        while ((qcnt(0) > 0 || qcnt(1) > 0) && guard < 60) begin
            run_cycle(100, 1'b1);
            guard++;
        end
        check("t5_drained", 32'(qcnt(0) + qcnt(1)), 32'h0);
        compare_streams("t5_stream");

        // ---- random traffic against the model ----
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            int pv;
            pv = (ph == 0) ? 90 : (ph == 1) ? 30 : 3;
            for (int c = 0; c < 250; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (qcnt(i) == 0 && $urandom_range(9) == 0) begin
                        int n;
                        n = $urandom_range(6, 1);
                        for (int j = 0; j < n; j++) qpush(i, 8'($urandom));
                    end
                end
                run_cycle(pv, $urandom_range(99) < 70);
            end
        end
        compare_streams("rand_stream");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
